// File: rtl/pipe_decode_pkg.sv
// Shared Y86-64 decode constants: instruction codes, register IDs and the D-register NOP state.
// Included by pipe_decode and pipe_regfile via import pipe_decode_pkg::*.
package pipe_decode_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] RRSP    = 4'h4;

  localparam logic [3:0] NOP_ICODE = INOP;
  localparam logic [3:0] NOP_IFUN  = 4'h0;

endpackage

// File: rtl/pipe_decode_regfile.sv
// pipe_regfile: NREG x WORD_W register file, two combinational read ports, two write ports
// (M port wins on a shared destination) and an asynchronous active-low clear.
module pipe_regfile
  import pipe_decode_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int NREG   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        src_a,
  input  logic [3:0]        src_b,
  output logic [WORD_W-1:0] val_a,
  output logic [WORD_W-1:0] val_b,
  input  logic [3:0]        dst_e,
  input  logic [WORD_W-1:0] wval_e,
  input  logic [3:0]        dst_m,
  input  logic [WORD_W-1:0] wval_m
);

  logic [WORD_W-1:0] regs [NREG];

  // IDs at or above NREG (including RNONE) never match an entry, so such writes fall away.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic [WORD_W-1:0] q_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          q_reg <= '0;
        end else if (dst_m == 4'(gi)) begin
          q_reg <= wval_m;
        end else if (dst_e == 4'(gi)) begin
          q_reg <= wval_e;
        end
      end

      assign regs[gi] = q_reg;
    end
  endgenerate

  assign val_a = (int'(src_a) < NREG) ? regs[src_a] : '0;
  assign val_b = (int'(src_b) < NREG) ? regs[src_b] : '0;

endmodule

// File: rtl/pipe_decode.sv
// pipe_decode: Y86-64 decode stage (D register, register file, source/dest selection, operands).
// Define PIPE_DECODE_FORWARD_EN to forward from E/M/W; otherwise any pending write to a source stalls.
module pipe_decode
  import pipe_decode_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int NREG   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              D_stall,
  input  logic              D_bubble,
  input  logic [3:0]        f_icode,
  input  logic [3:0]        f_ifun,
  input  logic [3:0]        f_rA,
  input  logic [3:0]        f_rB,
  input  logic [WORD_W-1:0] f_valC,
  input  logic [WORD_W-1:0] f_valP,
  input  logic [3:0]        e_dstE,
  input  logic [WORD_W-1:0] e_valE,
  input  logic [3:0]        E_dstM,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  input  logic [WORD_W-1:0] M_valE,
  input  logic [WORD_W-1:0] m_valM,
  input  logic [3:0]        W_dstE,
  input  logic [3:0]        W_dstM,
  input  logic [WORD_W-1:0] W_valE,
  input  logic [WORD_W-1:0] W_valM,
  output logic [3:0]        d_icode,
  output logic [3:0]        d_ifun,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [3:0]        d_dstE,
  output logic [3:0]        d_dstM,
  output logic [WORD_W-1:0] d_valA,
  output logic [WORD_W-1:0] d_valB,
  output logic [WORD_W-1:0] d_valC,
  output logic              d_hazard,
  output logic              d_bad_icode
);

  logic [3:0]        dr_icode_reg;
  logic [3:0]        dr_ifun_reg;
  logic [3:0]        dr_ra_reg;
  logic [3:0]        dr_rb_reg;
  logic [WORD_W-1:0] dr_valc_reg;
  logic [WORD_W-1:0] dr_valp_reg;

  logic [WORD_W-1:0] rf_a;
  logic [WORD_W-1:0] rf_b;
  logic [WORD_W-1:0] opnd_a;
  logic [WORD_W-1:0] opnd_b;

  // Stall outranks bubble so a stalled instruction is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dr_icode_reg <= NOP_ICODE;
      dr_ifun_reg  <= NOP_IFUN;
      dr_ra_reg    <= RNONE;
      dr_rb_reg    <= RNONE;
      dr_valc_reg  <= '0;
      dr_valp_reg  <= '0;
    end else if (D_stall) begin
      dr_icode_reg <= dr_icode_reg;
    end else if (D_bubble) begin
      dr_icode_reg <= NOP_ICODE;
      dr_ifun_reg  <= NOP_IFUN;
      dr_ra_reg    <= RNONE;
      dr_rb_reg    <= RNONE;
      dr_valc_reg  <= '0;
      dr_valp_reg  <= '0;
    end else begin
      dr_icode_reg <= f_icode;
      dr_ifun_reg  <= f_ifun;
      dr_ra_reg    <= f_rA;
      dr_rb_reg    <= f_rB;
      dr_valc_reg  <= f_valC;
      dr_valp_reg  <= f_valP;
    end
  end

  always_comb begin
    d_srcA      = RNONE;
    d_srcB      = RNONE;
    d_dstE      = RNONE;
    d_dstM      = RNONE;
    d_bad_icode = 1'b0;
    case (dr_icode_reg)
      IRRMOVQ: begin d_srcA = dr_ra_reg; d_dstE = dr_rb_reg; end
      IIRMOVQ: begin d_dstE = dr_rb_reg; end
      IRMMOVQ: begin d_srcA = dr_ra_reg; d_srcB = dr_rb_reg; end
      IMRMOVQ: begin d_srcB = dr_rb_reg; d_dstM = dr_ra_reg; end
      IOPQ:    begin d_srcA = dr_ra_reg; d_srcB = dr_rb_reg; d_dstE = dr_rb_reg; end
      ICALL:   begin d_srcB = RRSP; d_dstE = RRSP; end
      IRET:    begin d_srcA = RRSP; d_srcB = RRSP; d_dstE = RRSP; end
      IPUSHQ:  begin d_srcA = dr_ra_reg; d_srcB = RRSP; d_dstE = RRSP; end
      IPOPQ:   begin d_srcA = RRSP; d_srcB = RRSP; d_dstE = RRSP; d_dstM = dr_ra_reg; end
      INOP, IHALT, IJXX: begin end
      default: d_bad_icode = 1'b1;
    endcase
  end

  pipe_regfile #(
    .WORD_W (WORD_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .src_a  (d_srcA),
    .src_b  (d_srcB),
    .val_a  (rf_a),
    .val_b  (rf_b),
    .dst_e  (W_dstE),
    .wval_e (W_valE),
    .dst_m  (W_dstM),
    .wval_m (W_valM)
  );

`ifdef PIPE_DECODE_FORWARD_EN
  logic [3:0]        fwd_dst [5];
  logic [WORD_W-1:0] fwd_val [5];

  assign fwd_dst = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
  assign fwd_val = '{e_valE, m_valM, M_valE, W_valM, W_valE};

  // Walk from lowest to highest priority so the youngest producer overwrites older ones.
  always_comb begin
    opnd_a = rf_a;
    opnd_b = rf_b;
    for (int i = 4; i >= 0; i--) begin
      if (d_srcA != RNONE && d_srcA == fwd_dst[i]) opnd_a = fwd_val[i];
      if (d_srcB != RNONE && d_srcB == fwd_dst[i]) opnd_b = fwd_val[i];
    end
  end

  // Only a load still in execute cannot be forwarded in time.
  assign d_hazard = (E_dstM != RNONE) && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
`else
  logic [3:0] haz_dst [6];
  logic       unused_fwd;

  assign haz_dst    = '{e_dstE, E_dstM, M_dstE, M_dstM, W_dstE, W_dstM};
  assign unused_fwd = ^{e_valE, M_valE, m_valM};
  assign opnd_a     = rf_a;
  assign opnd_b     = rf_b;

  always_comb begin
    d_hazard = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if ((d_srcA != RNONE && d_srcA == haz_dst[i]) ||
          (d_srcB != RNONE && d_srcB == haz_dst[i])) begin
        d_hazard = 1'b1;
      end
    end
  end
`endif

  assign d_icode = dr_icode_reg;
  assign d_ifun  = dr_ifun_reg;
  assign d_valC  = dr_valc_reg;
  assign d_valA  = (dr_icode_reg == ICALL || dr_icode_reg == IJXX) ? dr_valp_reg : opnd_a;
  assign d_valB  = opnd_b;

endmodule

// File: tb/tb_pipe_decode.sv
// Testbench for pipe_decode: directed scenarios plus a randomized run against a behavioural model.
// Expectations follow PIPE_DECODE_FORWARD_EN when it is defined for the build.
module tb_pipe_decode;

  localparam logic [3:0] F = 4'hF;

  logic        clk = 1'b0;
  logic        rst;
  logic        D_stall, D_bubble;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic [3:0]  e_dstE, E_dstM, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valA, d_valB, d_valC;
  logic        d_hazard, d_bad_icode;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  logic [3:0]  m_icode, m_ifun, m_ra, m_rb;
  logic [63:0] m_valc, m_valp;
  logic [63:0] m_rf [16];

  always #5 clk = ~clk;

  pipe_decode dut (
    .clk(clk), .rst(rst), .D_stall(D_stall), .D_bubble(D_bubble),
    .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP),
    .e_dstE(e_dstE), .e_valE(e_valE), .E_dstM(E_dstM),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
    .d_icode(d_icode), .d_ifun(d_ifun), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .d_valA(d_valA), .d_valB(d_valB),
    .d_valC(d_valC), .d_hazard(d_hazard), .d_bad_icode(d_bad_icode)
  );

  // {srcA, srcB, dstE, dstM} straight from the instruction table
  function automatic logic [15:0] ids_of(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
    case (ic)
      4'h2:    return {ra, F, rb, F};
      4'h3:    return {F, F, rb, F};
      4'h4:    return {ra, rb, F, F};
      4'h5:    return {F, rb, F, ra};
      4'h6:    return {ra, rb, rb, F};
      4'h8:    return {F, 4'h4, 4'h4, F};
      4'h9:    return {4'h4, 4'h4, 4'h4, F};
      4'hA:    return {ra, 4'h4, 4'h4, F};
      4'hB:    return {4'h4, 4'h4, 4'h4, ra};
      default: return {F, F, F, F};
    endcase
  endfunction

  function automatic logic [63:0] rf_read(input logic [3:0] src);
    return (src < 4'd15) ? m_rf[src] : 64'h0;
  endfunction

  function automatic logic [63:0] operand(input logic [3:0] src);
`ifdef PIPE_DECODE_FORWARD_EN
    logic [3:0]  dl [5];
    logic [63:0] vl [5];
    dl = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    vl = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (src != F) begin
      for (int k = 0; k < 5; k++) if (dl[k] == src) return vl[k];
    end
`endif
    return rf_read(src);
  endfunction

  function automatic logic hazard_of(input logic [3:0] sa, input logic [3:0] sb);
`ifdef PIPE_DECODE_FORWARD_EN
    return (E_dstM != F) && (E_dstM == sa || E_dstM == sb);
`else
    logic [3:0] dl [6];
    logic h;
    dl = '{e_dstE, E_dstM, M_dstE, M_dstM, W_dstE, W_dstM};
    h = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if ((sa != F && sa == dl[k]) || (sb != F && sb == dl[k])) h = 1'b1;
    end
    return h;
`endif
  endfunction

  function automatic logic [3:0] rnd_id();
    return ($urandom_range(0, 1) == 0) ? F : 4'($urandom_range(0, 15));
  endfunction

  task automatic idle();
    D_stall = 1'b0; D_bubble = 1'b0;
    f_icode = 4'h1; f_ifun = 4'h0; f_rA = F; f_rB = F; f_valC = '0; f_valP = '0;
    e_dstE = F; E_dstM = F; M_dstE = F; M_dstM = F; W_dstE = F; W_dstM = F;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    #1;
    checks++; if (d_icode !== 4'h1) begin errors++; $display("FAIL reset_icode: got %h expected 1", d_icode); end
    checks++; if (d_ifun !== 4'h0) begin errors++; $display("FAIL reset_ifun: got %h expected 0", d_ifun); end
    checks++; if ({d_srcA, d_srcB, d_dstE, d_dstM} !== 16'hFFFF) begin errors++; $display("FAIL reset_ids: got %h expected ffff", {d_srcA, d_srcB, d_dstE, d_dstM}); end
    checks++; if ({d_valA, d_valB, d_valC} !== 192'h0) begin errors++; $display("FAIL reset_vals: got %h/%h/%h expected 0", d_valA, d_valB, d_valC); end
    checks++; if ({d_hazard, d_bad_icode} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {d_hazard, d_bad_icode}); end
  endtask

  task automatic test_opq_forward();
    idle();
    f_icode = 4'h6; f_rA = 4'h2; f_rB = 4'h3;
    e_dstE = 4'h3; e_valE = 64'h55; M_dstE = 4'h3; M_valE = 64'h77;
    tick();
    #1;
`ifdef PIPE_DECODE_FORWARD_EN
    checks++; if (d_valB !== 64'h55) begin errors++; $display("FAIL opq_valB: got %h expected 55", d_valB); end
    checks++; if (d_hazard !== 1'b0) begin errors++; $display("FAIL opq_hazard: got %b expected 0", d_hazard); end
`else
    checks++; if (d_valB !== 64'h0) begin errors++; $display("FAIL opq_valB: got %h expected 0", d_valB); end
    checks++; if (d_hazard !== 1'b1) begin errors++; $display("FAIL opq_hazard: got %b expected 1", d_hazard); end
`endif
    checks++; if (d_dstE !== 4'h3) begin errors++; $display("FAIL opq_dstE: got %h expected 3", d_dstE); end
    checks++; if (d_srcA !== 4'h2) begin errors++; $display("FAIL opq_srcA: got %h expected 2", d_srcA); end
    checks++; if (d_valA !== 64'h0) begin errors++; $display("FAIL opq_valA: got %h expected 0", d_valA); end
  endtask

  task automatic test_load_use();
    idle();
    f_icode = 4'h4; f_rA = 4'h1;
    tick();
    E_dstM = 4'h1;
    #1;
    checks++; if (d_hazard !== 1'b1) begin errors++; $display("FAIL lu_hazard: got %b expected 1", d_hazard); end
    checks++; if ({d_srcA, d_srcB} !== 8'h1F) begin errors++; $display("FAIL lu_src: got %h expected 1f", {d_srcA, d_srcB}); end
    D_stall = 1'b1; f_icode = 4'h6; f_rA = 4'h5; f_rB = 4'h6;
    tick();
    checks++; if (d_icode !== 4'h4 || d_srcA !== 4'h1) begin errors++; $display("FAIL lu_hold: got %h/%h expected 4/1", d_icode, d_srcA); end
    D_stall = 1'b0; E_dstM = F;
    tick();
    checks++; if (d_icode !== 4'h6 || d_srcB !== 4'h6) begin errors++; $display("FAIL lu_release: got %h/%h expected 6/6", d_icode, d_srcB); end
    checks++; if (d_hazard !== 1'b0) begin errors++; $display("FAIL lu_clear: got %b expected 0", d_hazard); end
  endtask

  task automatic test_same_dest();
    idle();
    W_dstE = 4'h4; W_dstM = 4'h4; W_valE = 64'h10; W_valM = 64'h20;
    f_icode = 4'h9; f_valC = 64'h1234;
    tick();
    W_dstE = F; W_dstM = F;
    #1;
    checks++; if (d_valA !== 64'h20) begin errors++; $display("FAIL same_valA: got %h expected 20", d_valA); end
    checks++; if (d_valB !== 64'h20) begin errors++; $display("FAIL same_valB: got %h expected 20", d_valB); end
    checks++; if ({d_srcA, d_dstE} !== 8'h44) begin errors++; $display("FAIL same_ids: got %h expected 44", {d_srcA, d_dstE}); end
    checks++; if (d_valC !== 64'h1234) begin errors++; $display("FAIL same_valC: got %h expected 1234", d_valC); end
  endtask

  task automatic test_stall_bubble();
    idle();
    f_icode = 4'h6; f_rA = 4'h7; f_rB = 4'h8;
    D_stall = 1'b1; D_bubble = 1'b1;
    tick();
    checks++; if (d_icode !== 4'h9 || d_srcA !== 4'h4 || d_valC !== 64'h1234) begin errors++; $display("FAIL sb_both: got %h/%h/%h expected 9/4/1234", d_icode, d_srcA, d_valC); end
    D_stall = 1'b0;
    tick();
    checks++; if (d_icode !== 4'h1 || d_srcA !== F || d_dstE !== F || d_valC !== 64'h0) begin errors++; $display("FAIL sb_bubble: got %h/%h/%h/%h expected 1/f/f/0", d_icode, d_srcA, d_dstE, d_valC); end
    D_bubble = 1'b0;
    tick();
    checks++; if (d_icode !== 4'h6 || d_srcA !== 4'h7) begin errors++; $display("FAIL sb_load: got %h/%h expected 6/7", d_icode, d_srcA); end
  endtask

  task automatic test_forward_disabled();
    idle();
    f_icode = 4'h2; f_rA = 4'h4; f_rB = 4'h5;
    tick();
    W_dstE = 4'h4; W_valE = 64'h99;
    #1;
`ifdef PIPE_DECODE_FORWARD_EN
    checks++; if (d_hazard !== 1'b0) begin errors++; $display("FAIL nofwd_hazard: got %b expected 0", d_hazard); end
    checks++; if (d_valA !== 64'h99) begin errors++; $display("FAIL nofwd_valA: got %h expected 99", d_valA); end
`else
    checks++; if (d_hazard !== 1'b1) begin errors++; $display("FAIL nofwd_hazard: got %b expected 1", d_hazard); end
    checks++; if (d_valA !== 64'h20) begin errors++; $display("FAIL nofwd_valA: got %h expected 20", d_valA); end
`endif
    checks++; if (d_dstE !== 4'h5) begin errors++; $display("FAIL nofwd_dstE: got %h expected 5", d_dstE); end
    tick();
    W_dstE = F;
    #1;
    checks++; if (d_valA !== 64'h99 || d_hazard !== 1'b0) begin errors++; $display("FAIL nofwd_written: got %h/%b expected 99/0", d_valA, d_hazard); end
  endtask

  task automatic test_call_jxx_bad();
    idle();
    f_icode = 4'h8; f_valP = 64'hABC;
    tick();
    checks++; if (d_valA !== 64'hABC) begin errors++; $display("FAIL call_valA: got %h expected abc", d_valA); end
    checks++; if ({d_srcA, d_srcB, d_dstE, d_dstM} !== 16'hF44F) begin errors++; $display("FAIL call_ids: got %h expected f44f", {d_srcA, d_srcB, d_dstE, d_dstM}); end
    checks++; if (d_valB !== 64'h99) begin errors++; $display("FAIL call_valB: got %h expected 99", d_valB); end
    f_icode = 4'h7; f_valP = 64'h777;
    tick();
    checks++; if (d_valA !== 64'h777 || d_dstE !== F) begin errors++; $display("FAIL jxx: got %h/%h expected 777/f", d_valA, d_dstE); end
    f_icode = 4'hD; f_rA = 4'h2; f_rB = 4'h3;
    tick();
    checks++; if (d_bad_icode !== 1'b1) begin errors++; $display("FAIL bad_flag: got %b expected 1", d_bad_icode); end
    checks++; if ({d_srcA, d_srcB, d_dstE, d_dstM} !== 16'hFFFF) begin errors++; $display("FAIL bad_ids: got %h expected ffff", {d_srcA, d_srcB, d_dstE, d_dstM}); end
  endtask

  task automatic test_random();
    logic [15:0] ids;
    logic [63:0] exp_a, exp_b;
    idle();
    rst = 1'b0;
    #2 rst = 1'b1;
    m_icode = 4'h1; m_ifun = 4'h0; m_ra = F; m_rb = F; m_valc = '0; m_valp = '0;
    for (int k = 0; k < 16; k++) m_rf[k] = '0;
    for (int n = 0; n < 400; n++) begin
      f_icode = 4'($urandom_range(0, 15)); f_ifun = 4'($urandom_range(0, 15));
      f_rA = 4'($urandom_range(0, 15)); f_rB = 4'($urandom_range(0, 15));
      f_valC = {$urandom, $urandom}; f_valP = {$urandom, $urandom};
      D_stall = ($urandom_range(0, 7) == 0); D_bubble = ($urandom_range(0, 7) == 0);
      e_dstE = rnd_id(); E_dstM = rnd_id(); M_dstE = rnd_id(); M_dstM = rnd_id();
      W_dstE = rnd_id(); W_dstM = rnd_id();
      e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom}; m_valM = {$urandom, $urandom};
      W_valE = {$urandom, $urandom}; W_valM = {$urandom, $urandom};
      #1;
      ids   = ids_of(m_icode, m_ra, m_rb);
      exp_a = (m_icode == 4'h8 || m_icode == 4'h7) ? m_valp : operand(ids[15:12]);
      exp_b = operand(ids[11:8]);
      checks++; if (d_icode !== m_icode) begin errors++; $display("FAIL rnd_icode n=%0d: got %h expected %h", n, d_icode, m_icode); end
      checks++; if (d_ifun !== m_ifun) begin errors++; $display("FAIL rnd_ifun n=%0d: got %h expected %h", n, d_ifun, m_ifun); end
      checks++; if ({d_srcA, d_srcB, d_dstE, d_dstM} !== ids) begin errors++; $display("FAIL rnd_ids n=%0d: got %h expected %h", n, {d_srcA, d_srcB, d_dstE, d_dstM}, ids); end
      checks++; if (d_valA !== exp_a) begin errors++; $display("FAIL rnd_valA n=%0d: got %h expected %h", n, d_valA, exp_a); end
      checks++; if (d_valB !== exp_b) begin errors++; $display("FAIL rnd_valB n=%0d: got %h expected %h", n, d_valB, exp_b); end
      checks++; if (d_valC !== m_valc) begin errors++; $display("FAIL rnd_valC n=%0d: got %h expected %h", n, d_valC, m_valc); end
      checks++; if (d_hazard !== hazard_of(ids[15:12], ids[11:8])) begin errors++; $display("FAIL rnd_hazard n=%0d: got %b expected %b", n, d_hazard, hazard_of(ids[15:12], ids[11:8])); end
      checks++; if (d_bad_icode !== (m_icode > 4'hB)) begin errors++; $display("FAIL rnd_bad n=%0d: got %b expected %b", n, d_bad_icode, m_icode > 4'hB); end
      // advance the model across the coming edge
      if (!D_stall) begin
        if (D_bubble) begin
          m_icode = 4'h1; m_ifun = 4'h0; m_ra = F; m_rb = F; m_valc = '0; m_valp = '0;
        end else begin
          m_icode = f_icode; m_ifun = f_ifun; m_ra = f_rA; m_rb = f_rB; m_valc = f_valC; m_valp = f_valP;
        end
      end
      if (W_dstE < 4'd15) m_rf[W_dstE] = W_valE;
      if (W_dstM < 4'd15) m_rf[W_dstM] = W_valM;
      tick();
    end
  endtask

  task automatic test_async_reset();
    idle();
    W_dstE = 4'h2; W_valE = 64'hDEAD;
    f_icode = 4'h6; f_rA = 4'h2; f_rB = 4'h2;
    tick();
    W_dstE = F;
    #1;
    checks++; if (d_valA !== 64'hDEAD) begin errors++; $display("FAIL ar_before: got %h expected dead", d_valA); end
    #2 rst = 1'b0;
    #1;
    checks++; if (d_icode !== 4'h1 || d_srcA !== F || d_valA !== 64'h0) begin errors++; $display("FAIL ar_immediate: got %h/%h/%h expected 1/f/0", d_icode, d_srcA, d_valA); end
    #1 rst = 1'b1;
    tick();
    checks++; if (d_icode !== 4'h6 || d_valA !== 64'h0) begin errors++; $display("FAIL ar_rf_cleared: got %h/%h expected 6/0", d_icode, d_valA); end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_opq_forward();
    test_load_use();
    test_same_dest();
    test_stall_bubble();
    test_forward_disabled();
    test_call_jxx_bad();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
